// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and word width for the serial adder datapath
package serial_adder_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: bit counter with clear, increment and terminal-count flag
module sipo_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  assign tc = cnt == CNT_W'(WIDTH - 1);
  // clear wins over increment; wrap to zero on terminal count
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= tc ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/sipo_collector.sv
// sipo_collector: collects LSB-first serial bits into a word and offers it on valid/ready
module sipo_collector
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] bit_cnt
);
  state_t state;
  logic [WIDTH-1:0] shreg, nxt;
  logic tc;
  assign nxt = {bit_in, shreg[WIDTH-1:1]};
  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(start || state != ST_SHIFT),
    .inc(bit_en),
    .cnt(bit_cnt),
    .tc (tc)
  );
  // framing FSM with registered busy/out_valid; start restarts, HOLD waits for handshake
  always_ff @(posedge clk)
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else
      case (state)
        ST_IDLE:
          if (start) begin
            state <= ST_SHIFT;
            shreg <= '0;
            busy  <= 1'b1;
          end
        ST_SHIFT:
          if (start) shreg <= '0;
          else if (bit_en) begin
            shreg <= nxt;
            if (tc) begin
              state     <= ST_HOLD;
              out_data  <= nxt;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        ST_HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= start ? ST_SHIFT : ST_IDLE;
            busy      <= start;
            shreg     <= '0;
          end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
endmodule
